// File: rtl/mem_access_scheduler.sv
// Request scheduler in front of a 4x4 sub-banked memory. It queues reads and writes,
// holds back a write that collides with a read on the same sub-bank, and returns read data.

module sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  // NOTE: storage has no reset; the count gates every use of it, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == FULL_CNT);
endmodule

module mem_access_scheduler #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 8,
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              rd_rsp_valid,
  output logic [DATA_W-1:0] rd_rsp_data,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {RD_PRI, WR_PRI} pri_t;

  pri_t                     r_pri;
  logic [SW-1:0]            r_starve;
  logic                     r_ren_d;
  logic                     r_rsp_valid;
  logic [DATA_W-1:0]        r_rsp_data;

  logic                     w_rd_push, w_wr_push;
  logic                     w_rd_empty, w_wr_empty;
  logic                     w_rd_full, w_wr_full;
  logic [ADDR_W-1:0]        w_rd_head;
  logic [ADDR_W+DATA_W-1:0] w_wr_head;
  logic [ADDR_W-1:0]        w_wr_head_addr;
  logic [DATA_W-1:0]        w_wr_head_data;
  logic                     w_conflict;
  logic                     w_rd_issue, w_wr_issue;
  logic [SW-1:0]            w_starve_inc;

  assign rd_req_ready = !w_rd_full;
  assign wr_req_ready = !w_wr_full;
  assign w_rd_push    = rd_req_valid && rd_req_ready;
  assign w_wr_push    = wr_req_valid && wr_req_ready;

  sched_fifo #(.W(ADDR_W), .DEPTH(QDEPTH)) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rd_push),
    .i_din   (rd_req_addr),
    .i_pop   (w_rd_issue),
    .o_head  (w_rd_head),
    .o_empty (w_rd_empty),
    .o_full  (w_rd_full)
  );

  sched_fifo #(.W(ADDR_W + DATA_W), .DEPTH(QDEPTH)) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr_push),
    .i_din   ({wr_req_addr, wr_req_data}),
    .i_pop   (w_wr_issue),
    .o_head  (w_wr_head),
    .o_empty (w_wr_empty),
    .o_full  (w_wr_full)
  );

  assign w_wr_head_addr = w_wr_head[ADDR_W+DATA_W-1:DATA_W];
  assign w_wr_head_data = w_wr_head[DATA_W-1:0];

  // The memory drops a write that shares a sub-bank with a same-cycle read, so never issue such a pair.
  assign w_conflict = !w_rd_empty && !w_wr_empty &&
                      (w_rd_head[ADDR_W-1 -: 4] == w_wr_head_addr[ADDR_W-1 -: 4]);
  assign w_rd_issue = !rst && !w_rd_empty && !(w_conflict && r_pri == WR_PRI);
  assign w_wr_issue = !rst && !w_wr_empty && !(w_conflict && r_pri == RD_PRI);

  assign mem_ren   = w_rd_issue;
  assign mem_wen   = w_wr_issue;
  assign mem_raddr = w_rd_issue ? w_rd_head      : '0;
  assign mem_waddr = w_wr_issue ? w_wr_head_addr : '0;
  assign mem_din   = w_wr_issue ? w_wr_head_data : '0;

  assign w_starve_inc = r_starve + SW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pri    <= RD_PRI;
      r_starve <= '0;
    end else begin
      case (r_pri)
        RD_PRI: begin
          if (w_wr_issue) begin
            r_starve <= '0;
          end else if (w_conflict) begin
            r_starve <= w_starve_inc;
            if (w_starve_inc == STARVE_MAX) r_pri <= WR_PRI;
          end
        end
        WR_PRI: begin
          if (w_wr_issue) begin
            r_pri    <= RD_PRI;
            r_starve <= '0;
          end
        end
        default: r_pri <= RD_PRI;
      endcase
    end
  end

  // dout changes at the edge that samples mem_ren; capture it one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ren_d     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_ren_d     <= w_rd_issue;
      r_rsp_valid <= r_ren_d;
      if (r_ren_d) r_rsp_data <= mem_dout;
    end
  end

  assign rd_rsp_valid = r_rsp_valid;
  assign rd_rsp_data  = r_rsp_data;
endmodule
